// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared definitions for the sequential single-precision divider.
// Holds the controller state encoding and the IEEE-754 binary32 constants
// used by the top level and the shift-add multiplier.
package fp_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_RECIP,
    ST_MULT,
    ST_NORM,
    ST_DONE
  } state_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          MANT_W     = 24;

endpackage

// File: rtl/fp_div_seq_mult24.sv
// seq_mult24: 24x24 unsigned shift-add multiplier, one multiplier bit per
// cycle, LSB first.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   start          load a/b and clear the accumulator
//   a, b           multiplicand and multiplier (24 bits each)
//   product        48-bit accumulator, complete after the done cycle
//   done           high during the 24th (last) accumulation cycle
module seq_mult24
  import fp_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MANT_W-1:0]     a,
  input  logic [MANT_W-1:0]     b,
  output logic [2*MANT_W-1:0]   product,
  output logic                  done
);

  logic [2*MANT_W-1:0] acc;
  logic [2*MANT_W-1:0] mcand;
  logic [MANT_W-1:0]   mplier;
  logic [4:0]          count;
  logic                running;

  // The multiplicand shifts left as the multiplier shifts right, so each
  // cycle only needs to inspect mplier[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{MANT_W{1'b0}}, a};
      mplier  <= b;
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
      if (count == 5'(MANT_W - 1)) running <= 1'b0;
    end
  end

  assign product = acc;
  assign done    = running && (count == 5'(MANT_W - 1));

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential binary32 divider computing rs1 * (1/rs2).
// Starts the external reciprocal unit, multiplies the dividend mantissa by
// the returned reciprocal mantissa, normalises with truncation and returns
// one result with a done pulse. Subnormals are flushed to zero.
// Ports:
//   i_clk, i_rst_n            clock and asynchronous active-low reset
//   i_start, i_rs1_f, i_rs2_f request and operands (sampled in IDLE)
//   o_recip_start             one-cycle start pulse to the reciprocal unit
//   o_recip_operand           latched divisor for the reciprocal unit
//   i_recip_value, i_recip_done reciprocal result and its valid pulse
//   o_result, o_done, o_busy  quotient, completion pulse, busy flag
module fp_div_seq
  import fp_div_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_rs1_f,
  input  logic [31:0] i_rs2_f,
  output logic        o_recip_start,
  output logic [31:0] o_recip_operand,
  input  logic [31:0] i_recip_value,
  input  logic        i_recip_done,
  output logic [31:0] o_result,
  output logic        o_done,
  output logic        o_busy
);

  state_t state, state_next;

  logic [31:0]         rs1_q;
  logic [31:0]         rs2_q;
  logic [31:0]         result_q;
  logic [7:0]          er_q;
  logic                rsign_q;

  logic                mult_start;
  logic                mult_done;
  logic [2*MANT_W-1:0] product;
  logic                unused_low_bits;

  logic                is_special;
  logic [31:0]         special_result;
  logic signed [9:0]   e_norm;
  logic [22:0]         frac;
  logic                q_sign;
  logic [31:0]         norm_result;

  // Special operands, highest priority first. Since subnormals are flushed,
  // a zero divisor wins over a zero dividend, so 0/0 yields infinity.
  always_comb begin
    is_special     = 1'b1;
    special_result = FP_QNAN;
    if (rs1_q[30:23] == FP_EXP_MAX || rs2_q[30:23] == FP_EXP_MAX)
      special_result = FP_QNAN;
    else if (rs2_q[30:23] == 8'd0)
      special_result = {rs1_q[31] ^ rs2_q[31], FP_EXP_MAX, 23'd0};
    else if (rs1_q[30:23] == 8'd0)
      special_result = {rs1_q[31] ^ rs2_q[31], 31'd0};
    else
      is_special = 1'b0;
  end

  // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the extra
  // exponent increment. The 10-bit signed exponent keeps under/overflow
  // visible before clamping. Low product bits are simply dropped (truncate).
  always_comb begin
    e_norm = {2'b00, rs1_q[30:23]} + {2'b00, er_q} + {9'd0, product[47]}
             - 10'(FP_BIAS);
    frac   = product[47] ? product[46:24] : product[45:23];
    q_sign = rs1_q[31] ^ rsign_q;
    if (e_norm >= 10'sd255)
      norm_result = {q_sign, FP_EXP_MAX, 23'd0};
    else if (e_norm <= 10'sd0)
      norm_result = {q_sign, 31'd0};
    else
      norm_result = {q_sign, e_norm[7:0], frac};
  end

  assign unused_low_bits = ^product[22:0];

  // The multiplier takes the reciprocal mantissa straight off the bus in
  // the cycle it is valid and holds it internally.
  assign mult_start = (state == ST_RECIP) && i_recip_done;

  seq_mult24 u_mult (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .start   (mult_start),
    .a       ({1'b1, rs1_q[22:0]}),
    .b       ({1'b1, i_recip_value[22:0]}),
    .product (product),
    .done    (mult_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (i_start) state_next = ST_CLASSIFY;
      ST_CLASSIFY: state_next = is_special ? ST_DONE : ST_RECIP;
      ST_RECIP:    if (i_recip_done) state_next = ST_MULT;
      ST_MULT:     if (mult_done) state_next = ST_NORM;
      ST_NORM:     state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Result is written on entry to DONE so it is visible with o_done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      er_q     <= '0;
      rsign_q  <= 1'b0;
    end else begin
      if (state == ST_IDLE && i_start) begin
        rs1_q <= i_rs1_f;
        rs2_q <= i_rs2_f;
      end
      if (mult_start) begin
        er_q    <= i_recip_value[30:23];
        rsign_q <= i_recip_value[31];
      end
      if (state == ST_CLASSIFY && is_special) result_q <= special_result;
      if (state == ST_NORM) result_q <= norm_result;
    end
  end

  assign o_result        = result_q;
  assign o_recip_operand = rs2_q;
  assign o_done          = (state == ST_DONE);
  assign o_busy          = (state != ST_IDLE);
  assign o_recip_start   = (state == ST_CLASSIFY) && !is_special;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: self-checking bench for fp_div_seq. A behavioural
// reciprocal responder answers o_recip_start after a programmable latency,
// either with an exact 1/x for powers of two or with an arbitrary value.
module tb_fp_div_seq;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_rs1_f;
  logic [31:0] i_rs2_f;
  logic        o_recip_start;
  logic [31:0] o_recip_operand;
  logic [31:0] i_recip_value;
  logic        i_recip_done;
  logic [31:0] o_result;
  logic        o_done;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  fp_div_seq dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_start         (i_start),
    .i_rs1_f         (i_rs1_f),
    .i_rs2_f         (i_rs2_f),
    .o_recip_start   (o_recip_start),
    .o_recip_operand (o_recip_operand),
    .i_recip_value   (i_recip_value),
    .i_recip_done    (i_recip_done),
    .o_result        (o_result),
    .o_done          (o_done),
    .o_busy          (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Exact reciprocal of a normal power of two: exponent mirrors about bias.
  function automatic logic [31:0] recip_pow2(input logic [31:0] x);
    return {x[31], 8'(254 - int'(x[30:23])), 23'h0};
  endfunction

  function automatic bit is_special_op(input logic [31:0] a, input logic [31:0] b);
    return a[30:23] == 8'hFF || b[30:23] == 8'hFF || a[30:23] == 8'h00 || b[30:23] == 8'h00;
  endfunction

  // Quotient a/b given the reciprocal value r the responder returns.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] r);
    longint p;
    int e;
    logic [22:0] f;
    logic s;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC00000;
    if (b[30:23] == 8'h00) return {a[31] ^ b[31], 8'hFF, 23'h0};
    if (a[30:23] == 8'h00) return {a[31] ^ b[31], 31'h0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, r[22:0]});
    e = int'(a[30:23]) + int'(r[30:23]) - 127;
    if (p >= (64'sd1 << 47)) begin
      f = 23'(p >> 24);
      e = e + 1;
    end else begin
      f = 23'(p >> 23);
    end
    s = a[31] ^ r[31];
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] ex;
    sel = $urandom_range(0, 15);
    if (sel == 0)      ex = 8'h00;
    else if (sel == 1) ex = 8'hFF;
    else               ex = 8'($urandom_range(1, 254));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  // One full operation with the responder inline. Cycle 0 is the cycle in
  // which i_start is sampled. glitch>0 pulses i_start with other operands.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                        input bit custom, input logic [31:0] cval, input int glitch,
                        output logic [31:0] res, output int done_cyc, output int starts,
                        output logic [31:0] sent, output bit busy_ok,
                        output bit operand_ok, output bit idle_after);
    int cyc;
    int rs_cyc;
    @(negedge i_clk);
    i_rs1_f = a;
    i_rs2_f = b;
    i_start = 1'b1;
    sent = custom ? cval : recip_pow2(b);
    rs_cyc = -1000;
    starts = 0;
    done_cyc = -1;
    res = 32'h0;
    busy_ok = 1'b1;
    operand_ok = 1'b1;
    @(posedge i_clk);
    cyc = 1;
    while (cyc < 200 && done_cyc < 0) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (glitch > 0 && cyc == glitch) begin
        i_start = 1'b1;
        i_rs1_f = ~a;
        i_rs2_f = 32'h3F800000;
      end
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (o_recip_start === 1'b1) begin
        starts++;
        rs_cyc = cyc;
        if (o_recip_operand !== b) operand_ok = 1'b0;
      end
      if (cyc == rs_cyc + lat) begin
        i_recip_done = 1'b1;
        i_recip_value = sent;
      end else begin
        i_recip_done = 1'b0;
        i_recip_value = $urandom;
      end
      if (o_done === 1'b1) begin
        done_cyc = cyc;
        res = o_result;
      end
      @(posedge i_clk);
      cyc++;
    end
    @(negedge i_clk);
    i_start = 1'b0;
    i_recip_done = 1'b0;
    idle_after = (o_busy === 1'b0) && (o_done === 1'b0);
  endtask

  task automatic test_reset();
    total++;
    if ({o_result, o_recip_operand, o_done, o_busy, o_recip_start} !== 67'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got result=%h operand=%h done=%b busy=%b rstart=%b, expected all 0",
               o_result, o_recip_operand, o_done, o_busy, o_recip_start);
    end
  endtask

  task automatic test_directed();
    logic [31:0] av[5] = '{32'h40C00000, 32'hC1000000, 32'h3F800000, 32'h7F000000, 32'h00800000};
    logic [31:0] bv[5] = '{32'h40000000, 32'h40000000, 32'h40800000, 32'h00800000, 32'h7F000000};
    logic [31:0] ev[5] = '{32'h40400000, 32'hC0800000, 32'h3E800000, 32'h7F800000, 32'h00000000};
    int lv[5] = '{3, 1, 5, 2, 4};
    logic [31:0] res, sent;
    int dc, st;
    bit bok, ook, idl;
    for (int i = 0; i < 5; i++) begin
      run_op(av[i], bv[i], lv[i], 1'b0, 32'h0, 0, res, dc, st, sent, bok, ook, idl);
      total++;
      if (res !== ev[i]) begin
        bad++;
        $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, ev[i]);
      end
      total++;
      if (dc != 27 + lv[i]) begin
        bad++;
        $display("[TB] FAIL directed_done_cycle[%0d]: got %0d expected %0d", i, dc, 27 + lv[i]);
      end
      total++;
      if (!(st == 1 && bok && ook && idl)) begin
        bad++;
        $display("[TB] FAIL directed_protocol[%0d]: starts=%0d busy_ok=%b operand_ok=%b idle_after=%b, expected 1/1/1/1",
                 i, st, bok, ook, idl);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] av[4] = '{32'h40A00000, 32'h00000000, 32'h7FC00000, 32'h3F800000};
    logic [31:0] bv[4] = '{32'h00000000, 32'h40400000, 32'h3F800000, 32'h7F800000};
    logic [31:0] ev[4] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000};
    logic [31:0] res, sent;
    int dc, st;
    bit bok, ook, idl;
    for (int i = 0; i < 4; i++) begin
      run_op(av[i], bv[i], 2, 1'b0, 32'h0, 0, res, dc, st, sent, bok, ook, idl);
      total++;
      if (res !== ev[i]) begin
        bad++;
        $display("[TB] FAIL special_result[%0d]: got %h expected %h", i, res, ev[i]);
      end
      total++;
      if (dc != 2 || st != 0 || !bok || !idl) begin
        bad++;
        $display("[TB] FAIL special_timing[%0d]: done_cycle=%0d starts=%0d busy_ok=%b idle_after=%b, expected 2/0/1/1",
                 i, dc, st, bok, idl);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, res, sent, exp_res;
    int lat, dc, st, exp_dc;
    bit bok, ook, idl, spec;
    for (int i = 0; i < 24; i++) begin
      a = rand_fp();
      b = rand_fp();
      r = {b[31], 8'($urandom_range(0, 254)), 23'($urandom)};
      lat = $urandom_range(1, 6);
      spec = is_special_op(a, b);
      exp_res = model_div(a, b, r);
      exp_dc = spec ? 2 : 27 + lat;
      run_op(a, b, lat, 1'b1, r, 0, res, dc, st, sent, bok, ook, idl);
      total++;
      if (res !== exp_res) begin
        bad++;
        $display("[TB] FAIL random_result[%0d]: a=%h b=%h recip=%h got %h expected %h",
                 i, a, b, r, res, exp_res);
      end
      total++;
      if (dc != exp_dc || st != (spec ? 0 : 1)) begin
        bad++;
        $display("[TB] FAIL random_timing[%0d]: done_cycle=%0d starts=%0d, expected %0d/%0d",
                 i, dc, st, exp_dc, spec ? 0 : 1);
      end
    end
  endtask

  task automatic test_start_during_mult();
    logic [31:0] res, sent;
    int dc, st;
    bit bok, ook, idl;
    run_op(32'h40C00000, 32'h40000000, 3, 1'b0, 32'h0, 12, res, dc, st, sent, bok, ook, idl);
    total++;
    if (res !== 32'h40400000 || dc != 30) begin
      bad++;
      $display("[TB] FAIL start_in_mult: got %h at cycle %0d, expected 40400000 at cycle 30", res, dc);
    end
    total++;
    if (!idl || st != 1) begin
      bad++;
      $display("[TB] FAIL start_in_mult_idle: idle_after=%b starts=%0d, expected 1/1", idl, st);
    end
  endtask

  task automatic test_stray_recip_done();
    logic [31:0] prev, res, sent;
    int dc, st, seen;
    bit bok, ook, idl;
    prev = o_result;
    seen = 0;
    @(negedge i_clk);
    i_recip_done = 1'b1;
    i_recip_value = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_recip_start !== 1'b0 || o_result !== prev) seen++;
    end
    i_recip_done = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL stray_recip_done: %0d cycles with activity, expected 0 (result=%h prev=%h)",
               seen, o_result, prev);
    end
    run_op(32'h3F800000, 32'h40800000, 2, 1'b0, 32'h0, 0, res, dc, st, sent, bok, ook, idl);
    total++;
    if (res !== 32'h3E800000 || dc != 29) begin
      bad++;
      $display("[TB] FAIL after_stray: got %h at cycle %0d, expected 3e800000 at cycle 29", res, dc);
    end
  endtask

  task automatic test_reset_mid_mult();
    logic [31:0] res, sent;
    int dc, st, activity;
    bit bok, ook, idl;
    @(negedge i_clk);
    i_rs1_f = 32'h40C00000;
    i_rs2_f = 32'h40000000;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_recip_done = 1'b1;
    i_recip_value = 32'h3F000000;
    @(negedge i_clk);
    i_recip_done = 1'b0;
    repeat (6) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    total++;
    if ({o_result, o_recip_operand, o_done, o_busy, o_recip_start} !== 67'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_mult: got result=%h operand=%h done=%b busy=%b rstart=%b, expected all 0",
               o_result, o_recip_operand, o_done, o_busy, o_recip_start);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    activity = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (o_done !== 1'b0 || o_recip_start !== 1'b0 || o_busy !== 1'b0) activity++;
    end
    total++;
    if (activity != 0) begin
      bad++;
      $display("[TB] FAIL abort_quiet: %0d active cycles after reset, expected 0", activity);
    end
    run_op(32'hC1000000, 32'h40000000, 4, 1'b0, 32'h0, 0, res, dc, st, sent, bok, ook, idl);
    total++;
    if (res !== 32'hC0800000 || dc != 31) begin
      bad++;
      $display("[TB] FAIL after_abort: got %h at cycle %0d, expected c0800000 at cycle 31", res, dc);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_rs1_f = 32'h0;
    i_rs2_f = 32'h0;
    i_recip_value = 32'h0;
    i_recip_done = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    test_reset();
    i_rst_n = 1'b1;
    test_directed();
    test_specials();
    test_random();
    test_start_during_mult();
    test_stray_recip_done();
    test_reset_mid_mult();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
